// File: rtl/pipe_stage_elastic_if.sv
// rtl/pipe_stage_elastic_if.sv - handshake, data/control and hazard signals of one elastic pipeline stage.
// The slave modport is the stage itself; master is the surrounding datapath.
interface pipe_stage_elastic_if #(
   parameter int DATA_W = 96,
   parameter int CTRL_W = 9
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;
   logic              hold;
   logic              flush;

   modport slave (
      input  in_valid, in_data, in_ctrl, out_ready, hold, flush,
      output in_ready, out_valid, out_data, out_ctrl
   );

   modport master (
      output in_valid, in_data, in_ctrl, out_ready, hold, flush,
      input  in_ready, out_valid, out_data, out_ctrl
   );
endinterface

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic main+skid pipeline register with hold, flush and bubble-safe control.
// Optional saturating stall/bubble/flush counters when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_elastic #(
   parameter int                DATA_W      = 96,
   parameter int                CTRL_W      = 9,
   parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
   parameter int                CNT_W       = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   pipe_stage_elastic_if.slave  bus
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0]     stall_cnt,
   output logic [CNT_W-1:0]     bubble_cnt,
   output logic [CNT_W-1:0]     flush_cnt
`endif
);

   typedef enum logic [1:0] {
      SEL_KEEP,
      SEL_IN,
      SEL_SKID
   } mainSelT;

   logic              mainValid;
   logic              skidValid;
   logic [DATA_W-1:0] mainData;
   logic [CTRL_W-1:0] mainCtrl;
   logic [DATA_W-1:0] skidData;
   logic [CTRL_W-1:0] skidCtrl;

   logic              upXfer;
   logic              dnXfer;
   logic              mainValidNxt;
   logic              skidValidNxt;
   logic              skidLoad;
   mainSelT           mainSel;

   // in_ready is the skid-empty flop itself, so it is registered by construction.
   always_comb begin
      upXfer       = bus.in_valid & ~skidValid & ~bus.hold & ~bus.flush;
      dnXfer       = mainValid & bus.out_ready & ~bus.hold;
      mainValidNxt = mainValid;
      skidValidNxt = skidValid;
      skidLoad     = 1'b0;
      mainSel      = SEL_KEEP;
      if (bus.flush) begin
         mainValidNxt = 1'b0;
         skidValidNxt = 1'b0;
      end else if (!bus.hold) begin
         if (dnXfer && skidValid) begin
            mainSel      = SEL_SKID;
            mainValidNxt = 1'b1;
            skidValidNxt = 1'b0;
         end else if (upXfer && (dnXfer || !mainValid)) begin
            mainSel      = SEL_IN;
            mainValidNxt = 1'b1;
         end else if (upXfer) begin
            skidLoad     = 1'b1;
            skidValidNxt = 1'b1;
         end else if (dnXfer) begin
            mainValidNxt = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mainValid <= 1'b0;
         skidValid <= 1'b0;
         mainData  <= '0;
         mainCtrl  <= BUBBLE_CTRL;
         skidData  <= '0;
         skidCtrl  <= BUBBLE_CTRL;
      end else begin
         mainValid <= mainValidNxt;
         skidValid <= skidValidNxt;
         case (mainSel)
            SEL_IN: begin
               mainData <= bus.in_data;
               mainCtrl <= bus.in_ctrl;
            end
            SEL_SKID: begin
               mainData <= skidData;
               mainCtrl <= skidCtrl;
            end
            default: begin
               mainData <= mainData;
               mainCtrl <= mainCtrl;
            end
         endcase
         if (skidLoad) begin
            skidData <= bus.in_data;
            skidCtrl <= bus.in_ctrl;
         end
      end
   end

   // Control is forced to the bubble value whenever nothing valid is presented.
   assign bus.in_ready  = ~skidValid;
   assign bus.out_valid = mainValid & ~bus.hold;
   assign bus.out_data  = mainData;
   assign bus.out_ctrl  = (mainValid & ~bus.hold) ? mainCtrl : BUBBLE_CTRL;

`ifdef PIPE_STAGE_PERF_EN
   logic flushKill;
   logic bubbleCycle;

   assign flushKill   = bus.flush & (mainValid | skidValid);
   assign bubbleCycle = ~mainValid & ~bus.hold;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
         flush_cnt  <= '0;
      end else begin
         if (bus.hold && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
         if (bubbleCycle && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + 1'b1;
         end
         if (flushKill && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - scoreboard bench for pipe_stage_elastic (directed vectors, queue-based monitor).
module tb_pipe_stage_elastic;
   localparam int DW = 96;
   localparam int CW = 9;
   localparam logic [CW-1:0] BUB = '0;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   ctrlHits;
   logic [DW+CW-1:0] sb[$];

   pipe_stage_elastic_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();

`ifdef PIPE_STAGE_PERF_EN
   logic [15:0] stallCnt;
   logic [15:0] bubbleCnt;
   logic [15:0] flushCnt;
`endif

   pipe_stage_elastic #(
      .DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(BUB), .CNT_W(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
`ifdef PIPE_STAGE_PERF_EN
      ,
      .stall_cnt(stallCnt),
      .bubble_cnt(bubbleCnt),
      .flush_cnt(flushCnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DW-1:0] d, input logic [CW-1:0] c);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_ctrl  = c;
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
   endtask

   task automatic expect_out(input logic [DW-1:0] d, input logic [CW-1:0] c);
      sb.push_back({d, c});
   endtask

   // Monitor: a downstream transfer happens on the next edge when valid & ready.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.out_ctrl == 9'h1FF) ctrlHits++;
         if (bus.out_valid) begin
            if (bus.out_ready) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_output actual=%0h required=none", bus.out_data);
               end else begin
                  logic [DW+CW-1:0] e;
                  e = sb.pop_front();
                  chk("out_data", 128'(bus.out_data), 128'(e[DW+CW-1:CW]));
                  chk("out_ctrl", 128'(bus.out_ctrl), 128'(e[CW-1:0]));
               end
            end
         end else begin
            chk("bubble_ctrl", 128'(bus.out_ctrl), 128'(BUB));
         end
      end
   end

   initial begin
      checks = 0;
      errors = 0;
      ctrlHits = 0;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
      bus.in_ctrl = '0;
      bus.out_ready = 1'b0;
      bus.hold = 1'b0;
      bus.flush = 1'b0;
      #12;
      chk("reset_out_valid", 128'(bus.out_valid), 128'd0);
      chk("reset_in_ready", 128'(bus.in_ready), 128'd1);
      chk("reset_out_data", 128'(bus.out_data), 128'd0);
      chk("reset_out_ctrl", 128'(bus.out_ctrl), 128'(BUB));
`ifdef PIPE_STAGE_PERF_EN
      chk("reset_bubble_cnt", 128'(bubbleCnt), 128'd0);
      chk("reset_stall_cnt", 128'(stallCnt), 128'd0);
`endif
      rst = 1'b0;

      // Streaming
      bus.out_ready = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         send(DW'(i), CW'(i));
         expect_out(DW'(i), CW'(i));
         chk("stream_in_ready", 128'(bus.in_ready), 128'd1);
         step();
         chk("stream_latency", 128'(bus.out_data), 128'(i));
      end
      idle();
      step();
      step();
      chk("stream_idle_valid", 128'(bus.out_valid), 128'd0);

      // Backpressure
      bus.out_ready = 1'b0;
      expect_out(DW'('hA), CW'('hA));
      expect_out(DW'('hB), CW'('hB));
      expect_out(DW'('hC), CW'('hC));
      send(DW'('hA), CW'('hA));
      step();
      send(DW'('hB), CW'('hB));
      step();
      chk("bp_in_ready_full", 128'(bus.in_ready), 128'd0);
      chk("bp_main_data", 128'(bus.out_data), 128'hA);
      send(DW'('hC), CW'('hC));
      step();
      step();
      chk("bp_c_refused", 128'(bus.in_ready), 128'd0);
      chk("bp_still_a", 128'(bus.out_data), 128'hA);
      bus.out_ready = 1'b1;
      step();
      chk("bp_skid_drained", 128'(bus.in_ready), 128'd1);
      chk("bp_main_b", 128'(bus.out_data), 128'hB);
      step();
      idle();
      chk("bp_main_c", 128'(bus.out_data), 128'hC);
      step();
      step();
      chk("bp_drained", 128'(sb.size()), 128'd0);

      // Bubble control
      send(DW'('h77), 9'h1FF);
      expect_out(DW'('h77), 9'h1FF);
      step();
      idle();
      step();
      step();
      step();
      chk("bubble_ctrl_hits", 128'(ctrlHits), 128'd1);

      // Hold
      bus.out_ready = 1'b0;
      send(DW'('h11), CW'('h11));
      step();
      send(DW'('h22), CW'('h22));
      step();
      send(DW'('h99), CW'('h99));
      bus.hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("hold_out_valid", 128'(bus.out_valid), 128'd0);
         chk("hold_out_ctrl", 128'(bus.out_ctrl), 128'(BUB));
         chk("hold_in_ready", 128'(bus.in_ready), 128'd0);
         chk("hold_out_data", 128'(bus.out_data), 128'h11);
      end
`ifdef PIPE_STAGE_PERF_EN
      chk("stall_cnt", 128'(stallCnt), 128'd3);
`endif
      bus.hold = 1'b0;
      idle();
      expect_out(DW'('h11), CW'('h11));
      expect_out(DW'('h22), CW'('h22));
      bus.out_ready = 1'b1;
      step();
      step();
      step();
      chk("hold_drained", 128'(sb.size()), 128'd0);

      // Flush with both entries full and an offered input
      bus.out_ready = 1'b0;
      send(DW'('h44), CW'('h44));
      step();
      send(DW'('h55), CW'('h55));
      step();
      chk("flush_pre_full", 128'(bus.in_ready), 128'd0);
      send(DW'('h33), CW'('h33));
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      idle();
      chk("flush_out_valid", 128'(bus.out_valid), 128'd0);
      chk("flush_in_ready", 128'(bus.in_ready), 128'd1);
`ifdef PIPE_STAGE_PERF_EN
      chk("flush_cnt", 128'(flushCnt), 128'd1);
`endif
      bus.out_ready = 1'b1;
      step();
      step();
      step();

      // Flush and hold together: flush wins, offered input discarded
      bus.out_ready = 1'b0;
      send(DW'('h66), CW'('h66));
      step();
      send(DW'('h67), CW'('h67));
      bus.hold = 1'b1;
      bus.flush = 1'b1;
      step();
      bus.hold = 1'b0;
      bus.flush = 1'b0;
      idle();
      chk("flush_hold_valid", 128'(bus.out_valid), 128'd0);
      chk("flush_hold_ready", 128'(bus.in_ready), 128'd1);
      bus.out_ready = 1'b1;
      step();
      step();
      step();

      // Asynchronous reset mid-cycle with a full buffer
      bus.out_ready = 1'b0;
      send(DW'('h71), CW'('h71));
      step();
      send(DW'('h72), CW'('h72));
      step();
      idle();
      chk("rst_pre_valid", 128'(bus.out_valid), 128'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("rst_async_valid", 128'(bus.out_valid), 128'd0);
      chk("rst_async_ready", 128'(bus.in_ready), 128'd1);
      chk("rst_async_data", 128'(bus.out_data), 128'd0);
`ifdef PIPE_STAGE_PERF_EN
      chk("rst_stall_cnt", 128'(stallCnt), 128'd0);
      chk("rst_bubble_cnt", 128'(bubbleCnt), 128'd0);
      chk("rst_flush_cnt", 128'(flushCnt), 128'd0);
`endif
      #1;
      rst = 1'b0;
      bus.out_ready = 1'b1;
      send(DW'('h88), CW'('h88));
      expect_out(DW'('h88), CW'('h88));
      step();
      idle();
      chk("rst_first_accept_valid", 128'(bus.out_valid), 128'd1);
      chk("rst_first_accept_data", 128'(bus.out_data), 128'h88);
      step();
      step();

      chk("sb_empty", 128'(sb.size()), 128'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
